vga_frame_scanner: RTL
======================

Name: vga_frame_scanner

Overview:
- Coordinate-driving end of the game-to-display pixel interface.
- Sweeps VGAx/VGAy over the logical 320x240 screen and collects the 1-bit VGAcol that each game module returns after its fixed pipeline latency.
- Issues one framebuffer write (Plot, PlotX, PlotY, PlotCol) per pixel under a Ready handshake, and pulses FrameDone at the end of each frame.
- Sits between the active game module and the VGA framebuffer adapter.

Parameters:
- WIDTH, 320, pixels per line; x counts 0..WIDTH-1.
- HEIGHT, 240, lines per frame; y counts 0..HEIGHT-1.
- LATENCY, 2, clocks from a coordinate appearing on VGAx/VGAy to its valid VGAcol. Allowed range 1..4. Covers the registered pixindex plus the sprite ROM read.
- GAP, 16, idle clocks between FrameDone and the next frame's first issue (lets the game step state). Allowed range 1..65535.

Ports:
- Clock, in, 1, system clock.
- Reset, in, 1, reset.
- Enable, in, 1, scanning permitted.
- Ready, in, 1, framebuffer accepts a write this cycle.
- VGAcol, in, 1, pixel colour from the game module, valid LATENCY clocks after its coordinate.
- VGAx, out, 9, issued x coordinate.
- VGAy, out, 8, issued y coordinate.
- Plot, out, 1, write request.
- PlotX, out, 9, write x.
- PlotY, out, 8, write y.
- PlotCol, out, 1, write colour.
- FrameDone, out, 1, one-clock pulse when the last pixel of a frame is accepted.
- Busy, out, 1, high in SCAN or DRAIN.

Behaviour:
- Reset is synchronous, active-high; clock is Clock. All logic updates on posedge Clock.
- Reset forces state IDLE, scan position (0,0), all pipeline valid bits 0, GAP counter 0, and every output 0.
- Pipeline:
  - A LATENCY-deep shift register of {valid,x,y} advances every clock, unconditionally; the game module cannot be stalled.
  - Stage 0 takes {issue,VGAx,VGAy}.
  - At the last stage: Plot = valid, PlotX/PlotY = the stored coordinate, PlotCol = VGAcol sampled that cycle.
  - Plot, PlotX, PlotY and PlotCol are combinational from the last stage and VGAcol; no extra register.
- A write is accepted when Plot && Ready.
- Rewind (Plot && !Ready):
  - The write is dropped.
  - Scan position is reloaded with PlotX/PlotY.
  - All pipeline valid bits are cleared, including stages already issued.
  - State goes to SCAN.
  - Re-issue starts the following clock.
  - No pixel is written twice out of order and none is skipped; pixels are written strictly in raster order.
- States:
  - IDLE: issue=0, VGAx/VGAy=0, Busy=0. Enable=1 moves to SCAN with position (0,0).
  - SCAN: each clock issues the current position. x increments; at x=WIDTH-1, x goes to 0 and y increments. Issuing (WIDTH-1,HEIGHT-1) moves to DRAIN.
  - DRAIN: no issue; VGAx/VGAy hold the last issued value. A rewind goes back to SCAN. Acceptance of pixel (WIDTH-1,HEIGHT-1) pulses FrameDone in that same cycle and moves to GAP.
  - GAP: counts GAP clocks, Busy=0. At GAP-1: if Enable, go to SCAN at (0,0); else go to IDLE.
- Enable low in SCAN or DRAIN:
  - Next clock forces IDLE, flushes the pipeline, Plot=0.
  - The frame is abandoned with no FrameDone.
  - Re-enable restarts at (0,0).
- Enable low in GAP: the GAP count completes, then IDLE.
- Reset mid-frame: identical to the reset values above; no FrameDone.
- Simultaneous events:
  - Rewind has priority over advancing the scan.
  - Enable low has priority over rewind.
  - Reset has priority over all.
- Widths and counters:
  - x and y are held in 9 and 8 bits.
  - Comparisons use WIDTH-1/HEIGHT-1; counters never exceed them (no wrap past the screen).
  - The GAP counter is 16 bits.
- Nominal frame length with Ready held high: WIDTH*HEIGHT + LATENCY issue/drain clocks plus GAP clocks.

Test Plan:
- Reset, then Enable=1 and Ready=1, with WIDTH=4, HEIGHT=3, LATENCY=2 and a model returning VGAcol=x^y delayed 2 clocks:
  - 12 Plots in raster order with PlotCol=(x^y)&1.
  - First Plot is (0,0) two clocks after VGAx=0/VGAy=0 is first issued.
  - FrameDone pulses once, with Plot at (3,2).
- Same setup, Ready=0 for exactly the clock when Plot is at (1,1):
  - That write is dropped, the pipeline is flushed, and VGAx/VGAy return to (1,1).
  - Writes resume (1,1),(2,1),… with no duplicate or missing pixel.
  - The frame takes 3 extra clocks.
- Ready=0 when Plot is at (3,2), the last pixel in DRAIN:
  - The block returns to SCAN and re-issues (3,2).
  - FrameDone pulses only on the accepted write.
- Enable dropped after 5 accepted writes:
  - Next clock Busy=0 and Plot=0, with no FrameDone.
  - On re-enable, the first Plot is (0,0).
- Continuous Enable with GAP=3:
  - FrameDone is followed by exactly 3 clocks with Busy=0.
  - Then VGAx=0/VGAy=0 is issued.
- Reset asserted mid-DRAIN:
  - All outputs are 0 on the next clock, and IDLE is held until the next Enable.

Source files
------------

// File: rtl/vga_frame_scanner.sv
// Raster scanner feeding game-module pixel coordinates and forwarding the returned colour
// as framebuffer writes, with rewind-on-backpressure and an inter-frame gap.
module vga_frame_scanner #(
    parameter int unsigned WIDTH   = 320,
    parameter int unsigned HEIGHT  = 240,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned GAP     = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Ready,
    input  logic       VGAcol,
    output logic [8:0] VGAx,
    output logic [7:0] VGAy,
    output logic       Plot,
    output logic [8:0] PlotX,
    output logic [7:0] PlotY,
    output logic       PlotCol,
    output logic       FrameDone,
    output logic       Busy
);

    localparam logic [8:0]  XLast   = 9'(WIDTH - 1);
    localparam logic [7:0]  YLast   = 8'(HEIGHT - 1);
    localparam logic [15:0] GapLast = 16'(GAP - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StGap} state_e;

    state_e      state_q, state_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [15:0] gap_q, gap_d;

    logic [LATENCY-1:0] vld_q;
    logic [8:0]         px_q [LATENCY];
    logic [7:0]         py_q [LATENCY];

    logic issue;
    logic rewind;
    logic accept_last;
    logic flush;

    assign issue   = (state_q == StScan);
    assign Busy    = (state_q == StScan) || (state_q == StDrain);
    assign VGAx    = x_q;
    assign VGAy    = y_q;

    assign Plot    = vld_q[LATENCY-1];
    assign PlotX   = px_q[LATENCY-1];
    assign PlotY   = py_q[LATENCY-1];
    assign PlotCol = Plot & VGAcol;

    assign rewind      = Plot & ~Ready;
    assign accept_last = Plot & Ready & (PlotX == XLast) & (PlotY == YLast);
    // Dropping Enable abandons the frame, so the last write then does not count as completion.
    assign FrameDone   = accept_last & (state_q == StDrain) & Enable;
    assign flush       = (Busy & ~Enable) | rewind;

    // The game module cannot stall: the pipeline shifts every clock and is only ever flushed.
    always_ff @(posedge Clock) begin
        if (Reset || flush) begin
            vld_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue;
            px_q[0]  <= VGAx;
            py_q[0]  <= VGAy;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                px_q[i]  <= px_q[i-1];
                py_q[i]  <= py_q[i-1];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (Enable) begin
                    state_d = StScan;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StScan, StDrain: begin
                if (!Enable) begin
                    state_d = StIdle;
                    x_d     = '0;
                    y_d     = '0;
                end else if (rewind) begin
                    // Re-issue from the refused pixel so writes stay in raster order.
                    state_d = StScan;
                    x_d     = PlotX;
                    y_d     = PlotY;
                end else if (state_q == StScan) begin
                    if (x_q == XLast) begin
                        if (y_q == YLast) begin
                            state_d = StDrain;
                        end else begin
                            x_d = '0;
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                end else if (accept_last) begin
                    state_d = StGap;
                    x_d     = '0;
                    y_d     = '0;
                    gap_d   = '0;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = '0;
                    state_d = Enable ? StScan : StIdle;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
